// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port sync-write/async-read memory.
// One grant per cycle (round-robin or fixed priority), registered response one cycle later.
module mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic          p0_req_we,
    input  logic [AW-1:0] p0_req_addr,
    input  logic [DW-1:0] p0_req_wdata,
    output logic          p0_rsp_valid,
    output logic [DW-1:0] p0_rsp_rdata,
    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic          p1_req_we,
    input  logic [AW-1:0] p1_req_addr,
    input  logic [DW-1:0] p1_req_wdata,
    output logic          p1_rsp_valid,
    output logic [DW-1:0] p1_rsp_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          r_last_grant;
    logic          r_rsp_port;
    logic          r_rsp_pending;
    logic          r_rsp_is_write;
    logic [DW-1:0] r_rsp_data;

    logic          w_grant_valid;
    logic          w_grant_port;
    logic [1:0]    w_req_valid;
    logic [1:0]    w_req_we;
    logic [1:0]    w_ready;
    logic [1:0]    w_rsp_valid;
    logic [AW-1:0] w_req_addr  [2];
    logic [DW-1:0] w_req_wdata [2];
    logic [DW-1:0] w_rsp_rdata [2];

    assign w_req_valid    = {p1_req_valid, p0_req_valid};
    assign w_req_we       = {p1_req_we, p0_req_we};
    assign w_req_addr[0]  = p0_req_addr;
    assign w_req_addr[1]  = p1_req_addr;
    assign w_req_wdata[0] = p0_req_wdata;
    assign w_req_wdata[1] = p1_req_wdata;

    // Contest goes to the port that did not win last time unless port 0 is pinned.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_port  = 1'b0;
        if (!rst) begin
            if (&w_req_valid) begin
                w_grant_valid = 1'b1;
                w_grant_port  = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
            end else if (w_req_valid[0]) begin
                w_grant_valid = 1'b1;
                w_grant_port  = 1'b0;
            end else if (w_req_valid[1]) begin
                w_grant_valid = 1'b1;
                w_grant_port  = 1'b1;
            end
        end
    end

    // With no grant the port select stays 0, so the memory sees port 0's inputs.
    assign mem_we    = w_grant_valid && w_req_we[w_grant_port];
    assign mem_addr  = w_req_addr[w_grant_port];
    assign mem_wdata = w_req_wdata[w_grant_port];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign w_ready[gi]     = w_grant_valid && (w_grant_port == 1'(gi));
            assign w_rsp_valid[gi] = r_rsp_pending && (r_rsp_port == 1'(gi));
            assign w_rsp_rdata[gi] = (w_rsp_valid[gi] && !r_rsp_is_write) ? r_rsp_data : '0;
        end
    endgenerate

    assign p0_req_ready = w_ready[0];
    assign p1_req_ready = w_ready[1];
    assign p0_rsp_valid = w_rsp_valid[0];
    assign p1_rsp_valid = w_rsp_valid[1];
    assign p0_rsp_rdata = w_rsp_rdata[0];
    assign p1_rsp_rdata = w_rsp_rdata[1];

    // Read data is captured from the async memory in the grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant   <= 1'b1;
            r_rsp_port     <= 1'b0;
            r_rsp_pending  <= 1'b0;
            r_rsp_is_write <= 1'b0;
            r_rsp_data     <= '0;
        end else begin
            r_rsp_pending <= w_grant_valid;
            if (w_grant_valid) begin
                r_last_grant   <= w_grant_port;
                r_rsp_port     <= w_grant_port;
                r_rsp_is_write <= w_req_we[w_grant_port];
                r_rsp_data     <= w_req_we[w_grant_port] ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin and fixed-priority instances share stimulus,
// each with its own memory model; expected responses flow through a scoreboard queue.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
    logic [9:0]  p0_req_addr = '0;
    logic [31:0] p0_req_wdata = '0;
    logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [9:0]  p1_req_addr = '0;
    logic [31:0] p1_req_wdata = '0;

    logic        rr_p0_req_ready, rr_p1_req_ready, rr_p0_rsp_valid, rr_p1_rsp_valid, rr_mem_we;
    logic [31:0] rr_p0_rsp_rdata, rr_p1_rsp_rdata, rr_mem_wdata, rr_mem_rdata;
    logic [9:0]  rr_mem_addr;
    logic        fp_p0_req_ready, fp_p1_req_ready, fp_p0_rsp_valid, fp_p1_rsp_valid, fp_mem_we;
    logic [31:0] fp_p0_rsp_rdata, fp_p1_rsp_rdata, fp_mem_wdata, fp_mem_rdata;
    logic [9:0]  fp_mem_addr;

    logic [31:0] mem_rr [0:1023];
    logic [31:0] mem_fp [0:1023];

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    bit use_fp = 1'b0;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(10), .DW(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(rr_p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(rr_p0_rsp_valid), .p0_rsp_rdata(rr_p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(rr_p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(rr_p1_rsp_valid), .p1_rsp_rdata(rr_p1_rsp_rdata),
        .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_rdata(rr_mem_rdata)
    );

    mem_arbiter #(.AW(10), .DW(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(fp_p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(fp_p0_rsp_valid), .p0_rsp_rdata(fp_p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(fp_p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(fp_p1_rsp_valid), .p1_rsp_rdata(fp_p1_rsp_rdata),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_rdata(fp_mem_rdata)
    );

    // 1K x 32 memories: synchronous write, asynchronous read.
    assign rr_mem_rdata = mem_rr[rr_mem_addr];
    assign fp_mem_rdata = mem_fp[fp_mem_addr];
    always @(posedge clk) begin
        if (rr_mem_we) mem_rr[rr_mem_addr] <= rr_mem_wdata;
        if (fp_mem_we) mem_fp[fp_mem_addr] <= fp_mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    // g: expected grant (0 none, 1 port 0, 2 port 1); ed: expected response data for that grant.
    task automatic step(input bit v0, input bit w0, input logic [9:0] a0, input logic [31:0] d0,
                        input bit v1, input bit w1, input logic [9:0] a1, input logic [31:0] d1,
                        input int g, input logic [31:0] ed);
        logic        r0, r1, we, rv0, rv1;
        logic [9:0]  addr;
        logic [31:0] rd0, rd1;
        rsp_t        e;
        @(negedge clk);
        step_no++;
        p0_req_valid = v0; p0_req_we = w0; p0_req_addr = a0; p0_req_wdata = d0;
        p1_req_valid = v1; p1_req_we = w1; p1_req_addr = a1; p1_req_wdata = d1;
        #1;
        r0   = use_fp ? fp_p0_req_ready : rr_p0_req_ready;
        r1   = use_fp ? fp_p1_req_ready : rr_p1_req_ready;
        we   = use_fp ? fp_mem_we : rr_mem_we;
        addr = use_fp ? fp_mem_addr : rr_mem_addr;
        chk("p0_req_ready", 32'(r0), 32'(g == 1));
        chk("p1_req_ready", 32'(r1), 32'(g == 2));
        chk("mem_we", 32'(we), 32'((g == 1) ? w0 : (g == 2) ? w1 : 1'b0));
        if (g != 0) begin
            chk("mem_addr", 32'(addr), 32'((g == 1) ? a0 : a1));
            sb.push_back('{port: (g == 2), data: ed});
        end
        @(posedge clk);
        #1;
        rv0 = use_fp ? fp_p0_rsp_valid : rr_p0_rsp_valid;
        rv1 = use_fp ? fp_p1_rsp_valid : rr_p1_rsp_valid;
        rd0 = use_fp ? fp_p0_rsp_rdata : rr_p0_rsp_rdata;
        rd1 = use_fp ? fp_p1_rsp_rdata : rr_p1_rsp_rdata;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_valid_granted", 32'(e.port ? rv1 : rv0), 32'd1);
            chk("rsp_rdata_granted", e.port ? rd1 : rd0, e.data);
            chk("rsp_valid_other", 32'(e.port ? rv0 : rv1), 32'd0);
        end else begin
            chk("p0_rsp_valid_idle", 32'(rv0), 32'd0);
            chk("p1_rsp_valid_idle", 32'(rv1), 32'd0);
            chk("p0_rsp_rdata_idle", rd0, 32'd0);
            chk("p1_rsp_rdata_idle", rd1, 32'd0);
        end
        $display("step %0d %s rst=%0b grant=%0d rsp0=%0b/%h rsp1=%0b/%h",
                 step_no, use_fp ? "fp" : "rr", rst, g, rv0, rd0, rv1, rd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_rr[i] = '0;
            mem_fp[i] = '0;
        end
        // Reset with and without stimulus.
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 10'd1, 0, 1, 1, 10'd2, 32'h1, 0, 0);
        rst = 1'b0;

        // Basic write/read on port 0, cross-port visibility, never-written address.
        step(1, 1, 10'd1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h0);
        step(1, 0, 10'd1, 0,            0, 0, 0, 0, 1, 32'hDEADBEEF);
        step(0, 0, 0, 0, 1, 1, 10'd2, 32'h12345678, 2, 32'h0);
        step(1, 0, 10'd2, 0, 0, 0, 0, 0, 1, 32'h12345678);
        step(1, 0, 10'd3, 0, 0, 0, 0, 0, 1, 32'h0);
        step(1, 0, 10'd1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);

        // Fresh reset, then round-robin contest alternates starting with port 0.
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 1, 32'hDEADBEEF);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 2, 32'h12345678);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 1, 32'hDEADBEEF);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 2, 32'h12345678);

        // Idle cycles must not disturb the round-robin pointer.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 1, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 2, 32'h12345678);

        // Back-to-back grants to port 1 alone, then same-port read-after-write.
        step(0, 0, 0, 0, 1, 0, 10'd2, 0, 2, 32'h12345678);
        step(0, 0, 0, 0, 1, 1, 10'd7, 32'h0BADF00D, 2, 32'h0);
        step(0, 0, 0, 0, 1, 0, 10'd7, 0, 2, 32'h0BADF00D);

        // Reset during a pending write: no grant, no write, no response.
        rst = 1'b1;
        step(0, 0, 0, 0, 1, 1, 10'd5, 32'hA5A5A5A5, 0, 0);
        rst = 1'b0;
        step(1, 0, 10'd5, 0, 0, 0, 0, 0, 1, 32'h0);
        step(1, 0, 10'd1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);

        // Fixed priority: port 1 stalls while port 0 keeps requesting.
        use_fp = 1'b1;
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 1, 32'hDEADBEEF);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 1, 32'hDEADBEEF);
        step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0, 1, 32'hDEADBEEF);
        step(0, 0, 0, 0, 1, 0, 10'd2, 0, 2, 32'h12345678);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port 1K x 32 data memory (sync write, async read) between the instruction-fetch path (port 0) and the load/store path (port 1) of the KLP32 core. Accepts at most one request per cycle via valid/ready handshakes, drives the memory's write_enable/addr/write_data, and returns a registered response to the granted port one cycle later. Round-robin by default, with optional fixed priority for port 0.

## Interface
- AW, 10, word address width (matches memory addr)
- DW, 32, data width
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- p0_req_valid / p1_req_valid  input  1  request present
- p0_req_ready / p1_req_ready  output  1  request accepted this cycle (combinational grant)
- p0_req_we / p1_req_we  input  1  1 = write, 0 = read
- p0_req_addr / p1_req_addr  input  AW  word address
- p0_req_wdata / p1_req_wdata  input  DW  write data
- p0_rsp_valid / p1_rsp_valid  output  1  one-cycle response pulse
- p0_rsp_rdata / p1_rsp_rdata  output  DW  read data (0 for write acks)
- mem_we  output  1  to memory write_enable
- mem_addr  output  AW  to memory addr
- mem_wdata  output  DW  to memory write_data
- mem_rdata  input  DW  from memory read_data (async)

## Operation
- State: last_grant (1 bit), rsp_port (1 bit), rsp_pending (1 bit), rsp_data (DW), rsp_is_write (1 bit).
- Grant (combinational, per cycle, rst=0):
  - only one valid -> grant it.
  - both valid, FIXED_PRIO=0 -> grant port != last_grant; FIXED_PRIO=1 -> grant port 0.
  - none valid -> no grant; mem_we=0, mem_addr/mem_wdata hold port 0 inputs (don't-care, not checked).
- Granted port: req_ready=1; other port req_ready=0. Memory driven from granted port's addr/wdata; mem_we = granted we.
- On the grant edge: last_grant <= granted port; rsp_pending <= 1; rsp_port <= granted port; rsp_data <= we ? 0 : mem_rdata.
- No grant: rsp_pending <= 0; last_grant unchanged.
- Response: pX_rsp_valid = rsp_pending && rsp_port==X; pX_rsp_rdata = rsp_data when valid for X, else 0.
- No response backpressure; requester must accept response in the cycle it appears.
- Requester must hold addr/we/wdata stable while valid and not ready.

## Timing
- Reset (rst=1 sampled on edge): last_grant=1 (port 0 wins first contest), rsp_pending=0, rsp_data=0. While rst=1: both req_ready=0, mem_we=0, both rsp_valid=0 in the following cycle.
- rst asserted in a cycle with pending requests: nothing granted, no memory write occurs, any response due next cycle is dropped.
- Latency: request accepted in cycle N -> rsp_valid in cycle N+1. Write committed to memory at end of cycle N.
- Throughput: one access per cycle; back-to-back grants to same port allowed when the other is idle.
- Round-robin with both valid every cycle: grants alternate 0,1,0,1...
- Read of an address written by the other port in cycle N: read granted in N+1 or later returns new data; same-cycle conflict impossible (one grant per cycle).
- Read-after-write to same address by same port, consecutive cycles: returns new value.

## Test plan
- Reset, then p0 write addr 1 = 0xDEADBEEF -> p0_req_ready=1 same cycle, p0_rsp_valid next cycle with rdata 0; p0 read addr 1 -> rsp rdata 0xDEADBEEF one cycle after grant.
- Both ports valid continuously for 4 cycles (p0 read addr 1, p1 read addr 2 after 0x12345678 written) -> grant order 0,1,0,1; responses alternate with correct data, p1_rsp_rdata=0x12345678.
- FIXED_PRIO=1, both valid 3 cycles then p0 drops -> p1 stalled (ready=0) 3 cycles, granted in cycle 4; p1 holds request stable throughout.
- Read of never-written addr 3 -> rsp_rdata 0; write to addr 2 from p1 then read addr 2 from p0 next cycle -> 0x12345678 (isolation addr 1 still 0xDEADBEEF).
- Assert rst in the cycle p1 write (addr 5 = 0xA5A5A5A5) is valid -> p1_req_ready=0, mem_we=0, no rsp next cycle; after reset, p0 read addr 5 returns 0.
- Idle cycle between accesses -> rsp_valid deasserts for exactly one cycle; last_grant unchanged across idle.
